rtc_hms_alarm: RTL
==================

// Module: rtc_hms_alarm
// PURPOSE
//   Single-clock 24 h real-time clock (hh:mm:ss) with NUM_ALARM independent alarm channels,
//   each with ring timeout and snooze. Replaces derived-clock counters: one clk, internal
//   1 Hz enable pulse. Sits between switch front-end (debounced, edge-detected pulses) and
//   display/buzzer blocks.
// PARAMETERS
//   CLK_HZ      50_000_000  clk cycles per second tick (>=2)
//   NUM_ALARM   2           alarm channels (1..7)
//   RING_SEC    60          ticks an alarm rings before auto-stop (>=1)
//   SNOOZE_MIN  5           snooze length in minutes; countdown = SNOOZE_MIN*60 ticks (>=1)
// PORTS
//   clk          in   1            system clock
//   rst          in   1            synchronous reset, active-high
//   i_run        in   1            1: prescaler advances; 0: prescaler and time frozen
//   i_set_tgt    in   TW           0 = time, k = alarm k-1; TW = $clog2(NUM_ALARM+1)
//   i_set_sel    in   2            edit field: 0 none, 1 sec, 2 min, 3 hour
//   i_inc        in   1            one-cycle pulse: selected field +1
//   i_dec        in   1            one-cycle pulse: selected field -1
//   i_alarm_en   in   NUM_ALARM    per-channel arm enable (level)
//   i_snooze     in   1            one-cycle pulse: snooze all ringing channels
//   i_dismiss    in   1            one-cycle pulse: stop all ringing/snoozed channels
//   o_tick       out  1            one-cycle 1 Hz pulse
//   o_sec        out  6            displayed seconds 0..59 (0 when an alarm is displayed)
//   o_min        out  6            displayed minutes 0..59
//   o_hour       out  5            displayed hours 0..23
//   o_ring       out  NUM_ALARM    per-channel ringing
//   o_ring_any   out  1            OR of o_ring
// BEHAVIOUR
//   Reset: time 00:00:00, alarms 00:00, prescaler 0, all FSMs IDLE, o_tick=0, o_ring=0.
//   Prescaler: counts 0..CLK_HZ-1 while i_run; tick when cnt==CLK_HZ-1, cnt->0. Holds if !i_run.
//   Time: on tick sec+1; 59->0 carries min; min 59->0 carries hour; hour 23->0.
//   Edit (tgt valid, sel!=0, inc XOR dec): selected field +/-1 modulo its range, no carry
//     into other fields (min 59 inc -> 00; hour 0 dec -> 23). inc&dec together: no change.
//   Time edit cycle: tick in that cycle is discarded, prescaler cleared to 0.
//   Alarm edit: sel=1 (sec) ignored; tgt>NUM_ALARM ignored (display shows time).
//   Display: combinational mux of registered value of i_set_tgt target; invalid tgt -> time.
//   Match(k): in a tick cycle, next time == alarm_k hh:mm:00 and i_alarm_en[k].
//     Evaluated only on ticks; edits never trigger a match.
//   Channel FSM (registered; o_ring[k]=1 in RING, rises with time showing hh:mm:00):
//     IDLE   -> RING on match; load ring_cnt=RING_SEC
//     RING   -> tick: ring_cnt-1; reaching 0 -> IDLE
//            -> i_snooze -> SNOOZE, load snz_cnt=SNOOZE_MIN*60
//     SNOOZE -> tick: snz_cnt-1; reaching 0 -> RING, reload ring_cnt
//            -> further match while in SNOOZE: ignored
//     any    -> IDLE on i_dismiss (priority over i_snooze) or !i_alarm_en[k]
//   rst has priority over everything; mid-ring/snooze reset -> IDLE, outputs 0 next cycle.
//   Widths: snz_cnt $clog2(SNOOZE_MIN*60+1), ring_cnt $clog2(RING_SEC+1), prescaler
//     $clog2(CLK_HZ).
// STRUCTURE
//   Package rtc_pkg: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23; field-select encodings
//     (SEL_NONE/SEC/MIN/HOUR); channel state enum (ST_IDLE/ST_RING/ST_SNOOZE).
//   Sub-module rtc_alarm_channel: alarm hh:mm regs, edit logic, FSM, counters;
//     generate-instantiated NUM_ALARM times. Top holds prescaler, time regs, display mux.
// TESTING (sim with CLK_HZ=4, RING_SEC=3, SNOOZE_MIN=1)
//   1 Set time 23:59:58, i_run=1 -> o_tick every 4 clks; after 2 ticks 00:00:00.
//   2 Alarm0=07:30, en[0]=1, time 07:29:59 -> next tick time 07:30:00 and o_ring[0]=1,
//     o_ring_any=1; o_ring[0] drops after 3 ticks.
//   3 Ringing ch0, i_snooze -> o_ring[0]=0 next cycle; reasserts after 60 ticks.
//   4 Time min=59 inc -> min 00, hour unchanged; inc+dec same cycle -> no change;
//     hour 0 dec -> 23; alarm target sel=sec inc -> no change.
//   5 i_snooze+i_dismiss same cycle while ringing -> IDLE, no re-ring after 60 ticks;
//     en[0] low mid-ring -> o_ring[0]=0 next cycle.
//   6 rst during SNOOZE -> next cycle time 00:00:00, o_ring=0, no later re-ring.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants, field-select encodings and channel state type for the hh:mm:ss RTC.
package rtc_pkg;

   localparam logic [5:0] SEC_MAX  = 6'd59;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [4:0] HOUR_MAX = 5'd23;

   localparam logic [1:0] SEL_NONE = 2'd0;
   localparam logic [1:0] SEL_SEC  = 2'd1;
   localparam logic [1:0] SEL_MIN  = 2'd2;
   localparam logic [1:0] SEL_HOUR = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } ch_state_t;

   // +/-1 with wrap inside 0..max_v; used for every edit so no carry leaks out
   function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max_v,
                                            input logic up);
      if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
      else    return (v == 6'd0) ? max_v : v - 6'd1;
   endfunction

endpackage

// File: rtl/rtc_alarm_channel.sv
// One alarm channel: hh:mm compare registers, edit logic, ring/snooze FSM with tick counters.
module rtc_alarm_channel #(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_MIN = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       i_en,
   input  logic       i_snooze,
   input  logic       i_dismiss,
   input  logic       i_edit,
   input  logic [1:0] i_sel,
   input  logic       i_up,
   input  logic [4:0] i_nxt_hour,
   input  logic [5:0] i_nxt_min,
   input  logic [5:0] i_nxt_sec,
   output logic [4:0] o_hour,
   output logic [5:0] o_min,
   output logic       o_ring
);
   import rtc_pkg::*;

   // state     | meaning
   // ST_IDLE   | armed or disarmed, waiting for a tick that lands on hh:mm:00
   // ST_RING   | buzzing; ring_cnt ticks left before auto-stop
   // ST_SNOOZE | silenced; snz_cnt ticks left before ringing again

   localparam int SNZ_TICKS = SNOOZE_MIN * 60;
   localparam int RW = $clog2(RING_SEC + 1);
   localparam int SW = $clog2(SNZ_TICKS + 1);
   localparam logic [RW-1:0] RING_LOAD = RW'(RING_SEC);
   localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNZ_TICKS);

   ch_state_t     state;
   logic [RW-1:0] ring_cnt;
   logic [SW-1:0] snz_cnt;
   logic [4:0]    alm_hour;
   logic [5:0]    alm_min;
   logic [5:0]    hour_step;
   logic [5:0]    min_step;
   logic          match;

   always_comb begin
      hour_step = step_wrap({1'b0, alm_hour}, {1'b0, HOUR_MAX}, i_up);
      min_step  = step_wrap(alm_min, MIN_MAX, i_up);
   end

   assign match = i_tick && i_en && (i_nxt_hour == alm_hour) && (i_nxt_min == alm_min)
                  && (i_nxt_sec == 6'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ring_cnt <= '0;
         snz_cnt  <= '0;
         alm_hour <= '0;
         alm_min  <= '0;
      end else begin
         if (i_edit && (i_sel == SEL_MIN))  alm_min  <= min_step;
         if (i_edit && (i_sel == SEL_HOUR)) alm_hour <= hour_step[4:0];

         if (i_dismiss || !i_en) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (match) begin
                     state    <= ST_RING;
                     ring_cnt <= RING_LOAD;
                  end
               end
               ST_RING: begin
                  if (i_snooze) begin
                     state   <= ST_SNOOZE;
                     snz_cnt <= SNZ_LOAD;
                  end else if (i_tick) begin
                     ring_cnt <= ring_cnt - 1'b1;
                     if (ring_cnt == RW'(1)) state <= ST_IDLE;
                  end
               end
               ST_SNOOZE: begin
                  if (i_tick) begin
                     if (snz_cnt == SW'(1)) begin
                        state    <= ST_RING;
                        ring_cnt <= RING_LOAD;
                     end else begin
                        snz_cnt <= snz_cnt - 1'b1;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_hour = alm_hour;
   assign o_min  = alm_min;
   assign o_ring = (state == ST_RING);

endmodule

// File: rtl/rtc_hms_alarm.sv
// 24 h hh:mm:ss clock on a single clock domain with an internal 1 Hz enable and
// NUM_ALARM independent alarm channels; display shows whichever target is being edited.
module rtc_hms_alarm #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int NUM_ALARM  = 2,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_MIN = 5,
   localparam int TW = $clog2(NUM_ALARM + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_run,
   input  logic [TW-1:0]        i_set_tgt,
   input  logic [1:0]           i_set_sel,
   input  logic                 i_inc,
   input  logic                 i_dec,
   input  logic [NUM_ALARM-1:0] i_alarm_en,
   input  logic                 i_snooze,
   input  logic                 i_dismiss,
   output logic                 o_tick,
   output logic [5:0]           o_sec,
   output logic [5:0]           o_min,
   output logic [4:0]           o_hour,
   output logic [NUM_ALARM-1:0] o_ring,
   output logic                 o_ring_any
);
   import rtc_pkg::*;

   localparam int PW = $clog2(CLK_HZ);
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

   logic [PW-1:0] pre_cnt;
   logic [5:0]    sec, min;
   logic [4:0]    hour;
   logic [5:0]    nxt_sec, nxt_min;
   logic [4:0]    nxt_hour;
   logic [5:0]    sec_step, min_step, hour_step;
   logic          edit_req, time_edit, tick;

   logic [4:0]           alm_hour [NUM_ALARM];
   logic [5:0]           alm_min  [NUM_ALARM];
   logic [NUM_ALARM-1:0] ring;

   assign edit_req  = (i_set_sel != SEL_NONE) && (i_inc ^ i_dec);
   assign time_edit = edit_req && (i_set_tgt == '0);
   // a time edit swallows the tick so the edited value is never bumped in the same cycle
   assign tick      = i_run && (pre_cnt == PRE_MAX) && !time_edit;

   always_ff @(posedge clk) begin
      if (rst)                    pre_cnt <= '0;
      else if (time_edit || tick) pre_cnt <= '0;
      else if (i_run)             pre_cnt <= pre_cnt + 1'b1;
   end

   always_comb begin
      nxt_sec  = sec + 6'd1;
      nxt_min  = min;
      nxt_hour = hour;
      if (sec == SEC_MAX) begin
         nxt_sec = 6'd0;
         if (min == MIN_MAX) begin
            nxt_min  = 6'd0;
            nxt_hour = (hour == HOUR_MAX) ? 5'd0 : hour + 5'd1;
         end else begin
            nxt_min = min + 6'd1;
         end
      end
   end

   always_comb begin
      sec_step  = step_wrap(sec, SEC_MAX, i_inc);
      min_step  = step_wrap(min, MIN_MAX, i_inc);
      hour_step = step_wrap({1'b0, hour}, {1'b0, HOUR_MAX}, i_inc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sec  <= '0;
         min  <= '0;
         hour <= '0;
      end else if (time_edit) begin
         case (i_set_sel)
            SEL_SEC:  sec  <= sec_step;
            SEL_MIN:  min  <= min_step;
            SEL_HOUR: hour <= hour_step[4:0];
            default:  ;
         endcase
      end else if (tick) begin
         sec  <= nxt_sec;
         min  <= nxt_min;
         hour <= nxt_hour;
      end
   end

   for (genvar g = 0; g < NUM_ALARM; g++) begin : g_ch
      rtc_alarm_channel #(
         .RING_SEC   (RING_SEC),
         .SNOOZE_MIN (SNOOZE_MIN)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .i_tick     (tick),
         .i_en       (i_alarm_en[g]),
         .i_snooze   (i_snooze),
         .i_dismiss  (i_dismiss),
         .i_edit     (edit_req && (i_set_tgt == TW'(g + 1))),
         .i_sel      (i_set_sel),
         .i_up       (i_inc),
         .i_nxt_hour (nxt_hour),
         .i_nxt_min  (nxt_min),
         .i_nxt_sec  (nxt_sec),
         .o_hour     (alm_hour[g]),
         .o_min      (alm_min[g]),
         .o_ring     (ring[g])
      );
   end

   always_comb begin
      o_sec  = sec;
      o_min  = min;
      o_hour = hour;
      for (int k = 0; k < NUM_ALARM; k++) begin
         if (i_set_tgt == TW'(k + 1)) begin
            o_sec  = 6'd0;
            o_min  = alm_min[k];
            o_hour = alm_hour[k];
         end
      end
   end

   assign o_tick     = tick;
   assign o_ring     = ring;
   assign o_ring_any = |ring;

endmodule
